// File: rtl/mem_data_ctrl_pkg.sv
// Shared definitions for the data-side memory controller.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (misaligned half/word accesses trap).
package mem_data_ctrl_pkg;

  localparam logic RST_ENABLE = 1'b1;
  localparam logic READ       = 1'b0;
  localparam logic WRITE      = 1'b1;

  localparam logic [1:0] WIDTH_B = 2'b00;
  localparam logic [1:0] WIDTH_H = 2'b01;
  localparam logic [1:0] WIDTH_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STORE = 2'd1,
    ST_LOAD  = 2'd2,
    ST_TRAP  = 2'd3
  } mem_state_e;

  // Number of bytes moved for a width code; code 11 behaves like a word.
  function automatic logic [2:0] width_bytes(input logic [1:0] width);
    case (width)
      WIDTH_B: width_bytes = 3'd1;
      WIDTH_H: width_bytes = 3'd2;
      default: width_bytes = 3'd4;
    endcase
  endfunction

  // True when a half is on an odd address or a word is not 4-byte aligned.
  function automatic logic misaligned(input logic [1:0] width, input logic [1:0] addr_lo);
    case (width)
      WIDTH_B: misaligned = 1'b0;
      WIDTH_H: misaligned = addr_lo[0];
      default: misaligned = (addr_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_data_ctrl_load_ext.sv
// Combinational load-result formatter: takes the four assembled little-endian
// bytes and zero- or sign-extends the low 1/2/4 bytes to 32 bits.
module mem_load_ext
  import mem_data_ctrl_pkg::*;
(
  input  logic [31:0] bytes_i,
  input  logic [1:0]  width_i,
  input  logic        unsigned_i,
  output logic [31:0] result_o
);

  logic fill_b;
  logic fill_h;

  // Extension bit is the top data bit for signed loads, zero otherwise.
  always_comb begin
    fill_b   = ~unsigned_i & bytes_i[7];
    fill_h   = ~unsigned_i & bytes_i[15];
    result_o = bytes_i;
    case (width_i)
      WIDTH_B: result_o = {{24{fill_b}}, bytes_i[7:0]};
      WIDTH_H: result_o = {{16{fill_h}}, bytes_i[15:0]};
      default: result_o = bytes_i;
    endcase
  end

endmodule

// File: rtl/mem_data_ctrl.sv
// Data-side memory controller: serializes one CPU load/store at a time onto a
// byte-wide RAM port, little-endian. Loads are pipelined (one address per
// cycle, data returns one cycle after its address) and extended at the end.
// Optional feature macro: MEM_MISALIGN_TRAP_EN -- misaligned half/word
// requests make no RAM access and answer with resp_err after one cycle.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// req_ready is low while an access is in flight, so req_valid is ignored then.
// resp_valid is a one-cycle pulse and req_ready is high in that same cycle,
// so a waiting request is taken on the edge that ends the response cycle.
module mem_data_ctrl
  import mem_data_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_width,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  input  logic [7:0]        din_ram,
  output logic [7:0]        dout_ram,
  output logic [ADDR_W-1:0] addr_ram,
  output logic              wr_ram,
  output mem_state_e        dbg_state
);

  mem_state_e        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;          // bytes issued to the RAM so far
  logic [1:0]        cap_idx_q, cap_idx_d;  // next load byte to capture
  logic              din_live_q, din_live_d; // din_ram now carries load data
  logic [2:0]        nbytes_q, nbytes_d;
  logic [1:0]        width_q, width_d;
  logic              unsigned_q, unsigned_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       cap_q, cap_d;

  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic [7:0]        dout_ram_q, dout_ram_d;
  logic [ADDR_W-1:0] addr_ram_q, addr_ram_d;
  logic              wr_ram_q, wr_ram_d;

  logic [31:0]       merged;
  logic [31:0]       ext_data;
  logic              last_byte;

  // Captured bytes with the byte arriving this cycle already slotted in, so
  // the final byte can be extended on the same edge it is captured.
  always_comb begin
    merged = cap_q;
    merged[{cap_idx_q, 3'b000} +: 8] = din_ram;
    last_byte = ({1'b0, cap_idx_q} == (nbytes_q - 3'd1));
  end

  mem_load_ext u_load_ext (
    .bytes_i    (merged),
    .width_i    (width_q),
    .unsigned_i (unsigned_q),
    .result_o   (ext_data)
  );

`ifdef MEM_MISALIGN_TRAP_EN
  logic resp_err_q, resp_err_d;
`endif

  // Next-state and registered-output logic for the access sequencer.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cap_idx_d    = cap_idx_q;
    din_live_d   = din_live_q;
    nbytes_d     = nbytes_q;
    width_d      = width_q;
    unsigned_d   = unsigned_q;
    wdata_d      = wdata_q;
    cap_d        = cap_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    dout_ram_d   = dout_ram_q;
    addr_ram_d   = addr_ram_q;
    wr_ram_d     = READ;
`ifdef MEM_MISALIGN_TRAP_EN
    resp_err_d   = resp_err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          nbytes_d    = width_bytes(req_width);
          width_d     = req_width;
          unsigned_d  = req_unsigned;
          wdata_d     = req_wdata;
          cnt_d       = 3'd1;
          cap_idx_d   = 2'd0;
          din_live_d  = 1'b0;
          cap_d       = 32'd0;
          req_ready_d = 1'b0;
          addr_ram_d  = req_addr;
          if (req_we) begin
            state_d    = ST_STORE;
            dout_ram_d = req_wdata[7:0];
            wr_ram_d   = WRITE;
          end else begin
            state_d = ST_LOAD;
          end
`ifdef MEM_MISALIGN_TRAP_EN
          // A trapped access leaves the RAM port untouched.
          if (misaligned(req_width, req_addr[1:0])) begin
            state_d    = ST_TRAP;
            addr_ram_d = addr_ram_q;
            dout_ram_d = dout_ram_q;
            wr_ram_d   = READ;
          end
`endif
        end
      end

      ST_STORE: begin
        if (cnt_q < nbytes_q) begin
          addr_ram_d = addr_ram_q + ADDR_W'(1);
          dout_ram_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
          wr_ram_d   = WRITE;
          cnt_d      = cnt_q + 3'd1;
        end else begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b1;
          resp_rdata_d = 32'd0;
          req_ready_d  = 1'b1;
`ifdef MEM_MISALIGN_TRAP_EN
          resp_err_d   = 1'b0;
`endif
        end
      end

      ST_LOAD: begin
        // Addresses stream out one per edge, independent of data return.
        if (cnt_q < nbytes_q) begin
          addr_ram_d = addr_ram_q + ADDR_W'(1);
          cnt_d      = cnt_q + 3'd1;
        end
        // The first edge in LOAD only launches; data follows one cycle behind.
        if (!din_live_q) begin
          din_live_d = 1'b1;
        end else begin
          cap_d     = merged;
          cap_idx_d = cap_idx_q + 2'd1;
          if (last_byte) begin
            state_d      = ST_IDLE;
            resp_valid_d = 1'b1;
            resp_rdata_d = ext_data;
            req_ready_d  = 1'b1;
`ifdef MEM_MISALIGN_TRAP_EN
            resp_err_d   = 1'b0;
`endif
          end
        end
      end

`ifdef MEM_MISALIGN_TRAP_EN
      ST_TRAP: begin
        state_d      = ST_IDLE;
        resp_valid_d = 1'b1;
        resp_rdata_d = 32'd0;
        resp_err_d   = 1'b1;
        req_ready_d  = 1'b1;
      end
`endif

      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 3'd0;
      cap_idx_q    <= 2'd0;
      din_live_q   <= 1'b0;
      nbytes_q     <= 3'd1;
      width_q      <= WIDTH_B;
      unsigned_q   <= 1'b0;
      wdata_q      <= 32'd0;
      cap_q        <= 32'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      dout_ram_q   <= 8'd0;
      addr_ram_q   <= '0;
      wr_ram_q     <= READ;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cap_idx_q    <= cap_idx_d;
      din_live_q   <= din_live_d;
      nbytes_q     <= nbytes_d;
      width_q      <= width_d;
      unsigned_q   <= unsigned_d;
      wdata_q      <= wdata_d;
      cap_q        <= cap_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      dout_ram_q   <= dout_ram_d;
      addr_ram_q   <= addr_ram_d;
      wr_ram_q     <= wr_ram_d;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  // Error flag holds until the next response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      resp_err_q <= 1'b0;
    end else begin
      resp_err_q <= resp_err_d;
    end
  end
  assign resp_err = resp_err_q;
`else
  assign resp_err = 1'b0;
`endif

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign dout_ram   = dout_ram_q;
  assign addr_ram   = addr_ram_q;
  assign wr_ram     = wr_ram_q;
  assign dbg_state  = state_q;

endmodule
